mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
Round-robin arbiter that shares one 2:1 datapath mux between two requesters using a valid/ready handshake.
- Grants one requester at a time and drives the mux select register.
- Forwards the granted requester's data, with per-grant beat counting, burst termination on a last flag, and bounded-burst preemption.
- Sits between two upstream producers and one downstream consumer.

Parameters:
DW, 8, data width of each requester and of the output
MAX_BEATS, 4, beats an owner may send before it must yield if the other requester is waiting (>=1)
CNT_W, 16, width of grant statistic counters (optional feature only)

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous reset, active-high
req0  input  1  requester 0 valid/request
data0  input  DW  requester 0 data
last0  input  1  requester 0 final beat of burst
ack0  output  1  requester 0 beat accepted
req1  input  1  requester 1 valid/request
data1  input  DW  requester 1 data
last1  input  1  requester 1 final beat of burst
ack1  output  1  requester 1 beat accepted
out_ready  input  1  downstream ready
out_valid  output  1  downstream valid
out_data  output  DW  muxed data
sel  output  1  registered mux select / current owner (0 = requester 0)
busy  output  1  a grant is active
gnt_cnt0  output  CNT_W  grants issued to requester 0 (optional feature only)
gnt_cnt1  output  CNT_W  grants issued to requester 1 (optional feature only)

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset state: IDLE, sel=0, prio=0, beat_cnt=0, busy=0. out_valid, ack0 and ack1 read 0 from the first cycle after the reset edge.
- Reset mid-burst aborts the grant with no further acks.
- States:
  - IDLE: no owner.
  - OWN: owner = sel.
- out_data = sel ? data1 : data0, combinational. In IDLE it shows data of the current sel.
- out_valid = OWN & req_sel.
- ack_sel = out_valid & out_ready. The non-owner ack is always 0.
- A beat transfers in a cycle where ack_sel=1.
- IDLE -> OWN on any request:
  - If exactly one req is high, that requester wins.
  - If both are high, requester prio wins.
  - At this edge: sel <= winner, beat_cnt <= 0, busy <= 1.
  - Latency: req rising in cycle N gives out_valid no earlier than cycle N+1.
- OWN -> IDLE (busy <= 0, prio <= ~sel) at the edge after any of:
  - a beat with last_sel=1;
  - a beat that makes beat_cnt+1 == MAX_BEATS while req_other=1 (preemption);
  - req_sel=0 in OWN (abort; no ack in that cycle).
- At least one IDLE cycle separates consecutive grants.
- beat_cnt increments on each beat and saturates at MAX_BEATS. If the other requester is idle, the owner continues past MAX_BEATS.
  - If the other requester requests after saturation, the owner releases after its next beat.
- out_ready low stalls: no ack, state held, beat_cnt held, data must stay stable.
- Requesters hold data/last stable while req=1 and not acked.
- Single-requester repeat grants: prio still toggles after each release, but an uncontested requester wins regardless of prio.
- MAX_BEATS=1: every beat releases if the other is waiting.

Optional Feature:
Macro MUX2_RR_ARBITER_STATS_EN.
- Defined: ports gnt_cnt0/gnt_cnt1 exist.
  - Each counter increments by 1 at each IDLE->OWN edge for its requester.
  - Counters wrap at 2^CNT_W and reset to 0 on rst.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all req=0 -> sel=0, busy=0, out_valid=0, ack0=ack1=0 every cycle.
- Single burst: req0=1, data0=0xA1,0xA2,0xA3 with last0 on third, out_ready=1 -> grant 1 cycle after req, out_data 0xA1/0xA2/0xA3 on consecutive cycles with ack0, then busy=0 and prio=1.
- Contention after reset: req0=req1=1 in same cycle, each 1-beat bursts with last=1 -> requester 0 granted first (sel=0), then IDLE cycle, then sel=1; order alternates 0,1,0,1 over 4 grants.
- Preemption: MAX_BEATS=4, req0 streaming with last0=0, req1 asserted -> exactly 4 acks to requester 0, IDLE, then sel=1 and ack1.
- Stall and abort: out_ready=0 for 3 cycles mid-burst -> no ack, out_data held. Then req0 dropped without last -> no ack, busy=0 next cycle.
- With MUX2_RR_ARBITER_STATS_EN and the contention test run twice -> gnt_cnt0=4, gnt_cnt1=4. Reset mid-burst -> both counters 0 and out_valid=0 next cycle.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester round-robin valid/ready arbiter driving a 2:1 mux; MUX2_RR_ARBITER_STATS_EN adds grant counters
module mux2_rr_arbiter #(
  parameter int DW = 8,
  parameter int MAX_BEATS = 4,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  input  logic          last0,
  output logic          ack0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  input  logic          last1,
  output logic          ack1,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          sel,
  output logic          busy
`ifdef MUX2_RR_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] MB = BW'(MAX_BEATS);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state, state_nx;
  logic prio, prio_nx, sel_nx;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic own, req_sel, req_oth, last_sel, win, beat, grant, rel;
  assign own      = state == OWN;
  assign req_sel  = sel ? req1 : req0;
  assign req_oth  = sel ? req0 : req1;
  assign last_sel = sel ? last1 : last0;
  assign win      = (req0 & req1) ? prio : req1;
  assign beat     = out_valid & out_ready;
  assign grant    = ~own & (req0 | req1);
  // release on last beat, on the bounded-burst limit while contended, or on abort
  assign rel      = own & (~req_sel | (beat & (last_sel | (req_oth & beat_cnt >= MB - 1'b1))));
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      prio     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      sel      <= sel_nx;
      prio     <= prio_nx;
      beat_cnt <= beat_nx;
    end
  end
  always_comb begin
    state_nx = grant ? OWN : rel ? IDLE : state;
    sel_nx   = grant ? win : sel;
    prio_nx  = rel ? ~sel : prio;
    beat_nx  = grant ? '0 : (beat && beat_cnt != MB) ? beat_cnt + 1'b1 : beat_cnt;
  end
  always_comb begin
    out_valid = own & req_sel & ~rst;
    ack0      = beat & ~sel;
    ack1      = beat & sel;
    busy      = own;
    out_data  = sel ? data1 : data0;
  end
`ifdef MUX2_RR_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (grant) begin
      gnt_cnt0 <= gnt_cnt0 + CNT_W'(~win);
      gnt_cnt1 <= gnt_cnt1 + CNT_W'(win);
    end
  end
`endif
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed stimulus with a beat scoreboard checked by an independent monitor
module tb_mux2_rr_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, last0 = 0, req1 = 0, last1 = 0, out_ready = 1;
  logic [7:0] data0 = 0, data1 = 0, out_data;
  logic ack0, ack1, out_valid, sel, busy;
`ifdef MUX2_RR_ARBITER_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif
  int n_chk = 0, n_pass = 0;
  logic [8:0] exp_q[$];
  mux2_rr_arbiter #(.DW(8), .MAX_BEATS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .sel(sel), .busy(busy)
`ifdef MUX2_RR_ARBITER_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", {23'd0, sel, out_data}, 32'h1ff);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("beat_sel_data", {23'd0, sel, out_data}, {23'd0, e});
        chk("beat_acks", {30'd0, ack1, ack0}, e[8] ? 32'd2 : 32'd1);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    req0 = 0; req1 = 0; last0 = 0; last1 = 0; out_ready = 1; rst = 1;
    tick(); tick();
    rst = 0;
  endtask
  task automatic send(input int who, input logic [7:0] d, input logic l);
    int n = 0;
    if (who == 0) begin req0 = 1; data0 = d; last0 = l; end
    else begin req1 = 1; data1 = d; last1 = l; end
    @(negedge clk);
    while (!(who == 0 ? ack0 : ack1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ack_wait", n < 50, 1);
    tick();
  endtask
  task automatic drop(input int who);
    if (who == 0) begin req0 = 0; last0 = 0; end
    else begin req1 = 0; last1 = 0; end
  endtask
  task automatic contention();
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b1, 8'h20});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h21});
    fork
      begin send(0, 8'h10, 1); send(0, 8'h11, 1); drop(0); end
      begin send(1, 8'h20, 1); send(1, 8'h21, 1); drop(1); end
    join
    tick();
    chk("contention_drain", exp_q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) rst = 0;
      chk("idle_sel", sel, 0);
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_acks", {ack1, ack0}, 0);
    end
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b0, 8'hA2});
    exp_q.push_back({1'b0, 8'hA3});
    req0 = 1; data0 = 8'hA1;
    #1;
    chk("grant_latency", out_valid, 0);
    send(0, 8'hA1, 0); send(0, 8'hA2, 0); send(0, 8'hA3, 1); drop(0);
    chk("burst_release", busy, 0);
    chk("burst_drain", exp_q.size(), 0);
    exp_q.push_back({1'b1, 8'hB1});
    exp_q.push_back({1'b0, 8'hB0});
    fork
      begin send(0, 8'hB0, 1); drop(0); end
      begin send(1, 8'hB1, 1); drop(1); end
    join
    tick();
    chk("prio_drain", exp_q.size(), 0);
    do_reset();
    contention();
    contention();
`ifdef MUX2_RR_ARBITER_STATS_EN
    chk("gnt_cnt0", gnt_cnt0, 4);
    chk("gnt_cnt1", gnt_cnt1, 4);
`endif
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'hE0 + 8'(i)});
    exp_q.push_back({1'b1, 8'hF0});
    exp_q.push_back({1'b0, 8'hE4});
    exp_q.push_back({1'b0, 8'hE5});
    fork
      begin for (int i = 0; i < 6; i++) send(0, 8'hE0 + 8'(i), i == 5); drop(0); end
      begin send(1, 8'hF0, 1); drop(1); end
    join
    tick();
    chk("preempt_drain", exp_q.size(), 0);
    do_reset();
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h60 + 8'(i)});
    exp_q.push_back({1'b1, 8'h70});
    exp_q.push_back({1'b0, 8'h67});
    fork
      begin for (int i = 0; i < 8; i++) send(0, 8'h60 + 8'(i), i == 7); drop(0); end
      begin repeat (7) @(posedge clk); #1; send(1, 8'h70, 1); drop(1); end
    join
    tick();
    chk("saturate_drain", exp_q.size(), 0);
    do_reset();
    exp_q.push_back({1'b0, 8'h30});
    exp_q.push_back({1'b0, 8'h31});
    req0 = 1; data0 = 8'h30; last0 = 0;
    tick(); tick();
    data0 = 8'h31; out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ack", ack0, 0);
      chk("stall_data", out_data, 8'h31);
      chk("stall_busy", busy, 1);
    end
    tick();
    out_ready = 1;
    tick();
    req0 = 0;
    @(negedge clk);
    chk("abort_ack", {ack1, ack0}, 0);
    chk("abort_valid", out_valid, 0);
    tick();
    chk("abort_busy", busy, 0);
    chk("stall_drain", exp_q.size(), 0);
    do_reset();
    exp_q.push_back({1'b0, 8'h50});
    exp_q.push_back({1'b1, 8'h40});
    fork
      begin send(0, 8'h50, 1); drop(0); end
      begin send(1, 8'h40, 1); drop(1); end
    join
    exp_q.push_back({1'b0, 8'h51});
    send(0, 8'h51, 0);
    data0 = 8'h52; rst = 1;
    #1;
    chk("rst_mid_ack", ack0, 0);
    tick();
    rst = 0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
`ifdef MUX2_RR_ARBITER_STATS_EN
    chk("rst_gnt_cnt0", gnt_cnt0, 0);
    chk("rst_gnt_cnt1", gnt_cnt1, 0);
`endif
    req0 = 0;
    tick(); tick();
    chk("rst_mid_drain", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
